// File: rtl/shift_reg_engine.sv
// shift_reg_engine: DATA_W-bit shift register serving SISO/SIPO/PISO/PIPO modes
// with valid/ready handshakes on both the input and the output side.
// Optional feature macro: SHIFT_REG_FLUSH_EN adds a synchronous flush input.
module shift_reg_engine #(
    parameter int unsigned DATA_W    = 8,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic              shift_reg_clk,
    input  logic              shift_reg_rst,
    input  logic [1:0]        shift_reg_mode,
    input  logic              shift_reg_din_vld,
    output logic              shift_reg_din_rdy,
    input  logic              shift_reg_sin,
    input  logic [DATA_W-1:0] shift_reg_pin,
    output logic              shift_reg_dout_vld,
    input  logic              shift_reg_dout_rdy,
    output logic              shift_reg_sout,
    output logic [DATA_W-1:0] shift_reg_pout,
    output logic              shift_reg_busy
`ifdef SHIFT_REG_FLUSH_EN
    ,
    input  logic              shift_reg_flush
`endif
);

    localparam int unsigned CW = $clog2(DATA_W);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_COLLECT = 2'd1;
    localparam logic [1:0] ST_EMIT    = 2'd2;

    localparam logic [CW-1:0] CNT_LAST = CW'(DATA_W - 1);

    logic [1:0]        state_q, state_d;
    logic [DATA_W-1:0] sreg_q, sreg_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [1:0]        mode_q, mode_d;

    logic              flush_w;
    logic              accept;
    logic              emit;
    logic [DATA_W-1:0] shift_in;
    logic [DATA_W-1:0] shift_out;
    logic              cur_bit;

`ifdef SHIFT_REG_FLUSH_EN
    assign flush_w = shift_reg_flush;
`else
    assign flush_w = 1'b0;
`endif

    // Handshake and status outputs decoded from state only (no path from dout_rdy).
    always_comb begin
        shift_reg_din_rdy  = (state_q == ST_IDLE) || (state_q == ST_COLLECT);
        shift_reg_dout_vld = (state_q == ST_EMIT);
        shift_reg_busy     = (state_q != ST_IDLE);
        accept             = shift_reg_din_vld && shift_reg_din_rdy;
        emit               = shift_reg_dout_vld && shift_reg_dout_rdy;
    end

    // Bit-order dependent shift paths: serial-in word and serial-out advance.
    always_comb begin
        if (MSB_FIRST) begin
            shift_in  = {sreg_q[DATA_W-2:0], shift_reg_sin};
            shift_out = {sreg_q[DATA_W-2:0], 1'b0};
            cur_bit   = sreg_q[DATA_W-1];
        end else begin
            shift_in  = {shift_reg_sin, sreg_q[DATA_W-1:1]};
            shift_out = {1'b0, sreg_q[DATA_W-1:1]};
            cur_bit   = sreg_q[0];
        end
    end

    // Data outputs: mode_q[0]==0 means serial output, 1 means parallel output.
    always_comb begin
        shift_reg_sout = 1'b0;
        shift_reg_pout = '0;
        if (state_q == ST_EMIT) begin
            if (mode_q[0]) shift_reg_pout = sreg_q;
            else           shift_reg_sout = cur_bit;
        end
    end

    // Next-state: IDLE accept latches mode; mode[1]==0 selects serial input.
    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    mode_d = shift_reg_mode;
                    if (!shift_reg_mode[1]) begin
                        sreg_d  = shift_in;
                        cnt_d   = CW'(1);
                        state_d = ST_COLLECT;
                    end else begin
                        sreg_d  = shift_reg_pin;
                        cnt_d   = '0;
                        state_d = ST_EMIT;
                    end
                end
            end
            ST_COLLECT: begin
                if (accept) begin
                    sreg_d = shift_in;
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        state_d = ST_EMIT;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            ST_EMIT: begin
                if (emit) begin
                    if (!mode_q[0]) begin
                        sreg_d = shift_out;
                        if (cnt_q == CNT_LAST) begin
                            cnt_d   = '0;
                            state_d = ST_IDLE;
                        end else begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end else begin
                        sreg_d  = '0;
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                sreg_d  = '0;
                cnt_d   = '0;
            end
        endcase
        // Flush overrides any same-cycle accept or emit.
        if (flush_w) begin
            state_d = ST_IDLE;
            sreg_d  = '0;
            cnt_d   = '0;
            mode_d  = '0;
        end
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge shift_reg_clk) begin
        if (shift_reg_rst) begin
            state_q <= ST_IDLE;
            sreg_q  <= '0;
            cnt_q   <= '0;
            mode_q  <= '0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
        end
    end

endmodule
